// File: rtl/rr_grant_ctrl_pkg.sv
// Shared constants for the round-robin grant controller and its picker.
package rr_grant_ctrl_pkg;

   localparam int unsigned N_REQ  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned HOLD_W = 8;

   // FSM state encoding, kept as plain constants for legacy compatibility
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Index to one-hot decode used to build the grant vector
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: rotate req so ptr lands at bit 0,
// priority-encode the lowest set bit, then add ptr back (mod 16).
module rr_pick
   import rr_grant_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   // Rotate right by ptr: rot[i] = req[(i + ptr) mod 16]
   always_comb begin
      logic [IDX_W-1:0] src;
      rot = '0;
      src = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         src    = IDX_W'(i) + ptr;
         rot[i] = req[src];
      end
   end

   // Lowest-set-bit priority encode of the rotated vector, then undo the rotation
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = IDX_W'(i);
         end
      end
      idx = off + ptr;
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one registered one-hot grant among 16 requesters,
// held until the owner releases or the hold timeout expires, then priority rotates.
module rr_grant_ctrl #(
   parameter int unsigned N_REQ    = rr_grant_ctrl_pkg::N_REQ,
   parameter int unsigned IDX_W    = rr_grant_ctrl_pkg::IDX_W,
   parameter int unsigned MAX_HOLD = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   import rr_grant_ctrl_pkg::*;

   // Timeout fires on the last permitted GRANT cycle; MAX_HOLD=0 disables it
   localparam bit                TO_EN     = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [0:0]        state_q,     state_d;
   logic [IDX_W-1:0]  ptr_q,       ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [N_REQ-1:0]  gnt_q,       gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic              timeout_q,   timeout_d;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              owner_req;

   rr_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req = req[gnt_idx_q];

   // Next-state logic: arbitration in IDLE, release/timeout/hold in GRANT
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            if (en && pick_found) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = pick_idx;
               gnt_d       = idx_to_onehot(pick_idx);
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
            end
         end

         ST_GRANT: begin
            // Release is checked first so it wins over a coincident timeout
            if (!owner_req) begin
               state_d     = ST_IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 1'b1;
            end else if (TO_EN && (hold_cnt_q == HOLD_LAST)) begin
               state_d     = ST_IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
               ptr_d       = gnt_idx_q + 1'b1;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d  = hold_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with a small expected-output scoreboard.
module tb_rr_grant_ctrl;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   typedef struct packed {
      logic [15:0] gnt;
      logic [3:0]  idx;
      logic        valid;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   rr_grant_ctrl #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare
   task automatic step(input string tag, input logic r, input logic e, input logic [15:0] rq,
                       input logic [3:0] ei, input logic ev, input logic et);
      exp_t x;
      exp_t got;
      rst     = r;
      en      = e;
      req     = rq;
      x.gnt   = ev ? (16'h0001 << ei) : 16'h0000;
      x.idx   = ei;
      x.valid = ev;
      x.to    = et;
      sb.push_back(x);
      @(posedge clk);
      #1;
      got.gnt   = gnt;
      got.idx   = gnt_idx;
      got.valid = gnt_valid;
      got.to    = timeout;
      x = sb.pop_front();
      n_tests++;
      assert (got === x) else begin
         n_fail++;
         $error("FAIL %s: got gnt=%h idx=%0d valid=%b to=%b, expected gnt=%h idx=%0d valid=%b to=%b",
                tag, got.gnt, got.idx, got.valid, got.to, x.gnt, x.idx, x.valid, x.to);
      end
   endtask

   initial begin
      logic [3:0] k4;
      rst = 1'b1;
      en  = 1'b0;
      req = 16'h0000;

      // Reset and idle with no requests
      step("reset", 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         step("idle_noreq", 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);

      // Pointer start at 0, rotation to 15, wrap back to 0
      step("b_grant0",   1'b0, 1'b1, 16'h8001, 4'd0,  1'b1, 1'b0);
      step("b_rel0",     1'b0, 1'b1, 16'h8000, 4'd0,  1'b0, 1'b0);
      step("b_grant15",  1'b0, 1'b1, 16'h8000, 4'd15, 1'b1, 1'b0);
      step("b_rel15",    1'b0, 1'b1, 16'h0003, 4'd15, 1'b0, 1'b0);
      step("b_wrap0",    1'b0, 1'b1, 16'h0003, 4'd0,  1'b1, 1'b0);
      step("b_rel_wrap", 1'b0, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0);

      // All requesting, each owner releases after 2 cycles: order 0..15,0
      step("c_rst", 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k <= 16; k++) begin
         k4 = 4'(k);
         step("c_grant", 1'b0, 1'b1, 16'hFFFF, k4, 1'b1, 1'b0);
         step("c_hold",  1'b0, 1'b1, 16'hFFFF, k4, 1'b1, 1'b0);
         step("c_rel",   1'b0, 1'b1, 16'hFFFF & ~(16'h0001 << k4), k4, 1'b0, 1'b0);
      end

      // Hold timeout at 4 cycles, re-grant, then release coinciding with the limit
      step("d_rst",   1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);
      step("d_grant", 1'b0, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         step("d_hold", 1'b0, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0);
      step("d_timeout", 1'b0, 1'b1, 16'h0010, 4'd4, 1'b0, 1'b1);
      step("d_regrant", 1'b0, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         step("d_hold2", 1'b0, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0);
      step("d_rel_at_limit", 1'b0, 1'b1, 16'h0000, 4'd4, 1'b0, 1'b0);
      step("d_idle",         1'b0, 1'b1, 16'h0000, 4'd4, 1'b0, 1'b0);

      // Enable gating: blocks new grants only
      step("e_en_low0",  1'b0, 1'b0, 16'h0100, 4'd4, 1'b0, 1'b0);
      step("e_en_low1",  1'b0, 1'b0, 16'h0100, 4'd4, 1'b0, 1'b0);
      step("e_grant8",   1'b0, 1'b1, 16'h0100, 4'd8, 1'b1, 1'b0);
      step("e_en_drop0", 1'b0, 1'b0, 16'h0100, 4'd8, 1'b1, 1'b0);
      step("e_en_drop1", 1'b0, 1'b0, 16'h0100, 4'd8, 1'b1, 1'b0);
      step("e_rel",      1'b0, 1'b0, 16'h0000, 4'd8, 1'b0, 1'b0);

      // Reset during a grant clears outputs and pointer
      step("f_grant5", 1'b0, 1'b1, 16'h0020, 4'd5, 1'b1, 1'b0);
      step("f_hold",   1'b0, 1'b1, 16'h0020, 4'd5, 1'b1, 1'b0);
      step("f_rst",    1'b1, 1'b1, 16'h0020, 4'd0, 1'b0, 1'b0);
      step("f_grant0", 1'b0, 1'b1, 16'h0021, 4'd0, 1'b1, 1'b0);
      step("f_rel",    1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
